alu_mc: RTL and testbench
=========================

# alu_mc

Multi-cycle, parametrised-width successor to the 32-bit combinational ALU. It accepts one operation per start pulse and executes logic and add/sub in one cycle. Shifts run iteratively, one bit per cycle, and multiply (optional) runs as shift-add. It sits between the register-file read stage and write-back, with a start/busy/done handshake so the controller can stall on long operations.

## Interface
- WIDTH, 32, operand/result width; must be ≥ 4 and a power of two
- SHW, $clog2(WIDTH), shift-amount field width (derived; do not override)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only when busy=0
- op_code  in  4  operation, latched at accept
- X  in  WIDTH  operand A, latched at accept
- Y  in  WIDTH  operand B, latched at accept
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse: result valid
- Z  out  WIDTH  result register
- overflow  out  1  signed add/sub overflow, or multiply high-half nonzero
- equal  out  1  latched X == Y
- zero  out  1  Z == 0 and op_code not reserved

## Operation
- op_code map:
  - 0 AND, 1 OR, 2 XOR, 3 NOR
  - 5 ADD, 6 SUB (two's complement)
  - 7 SLT: signed X<Y gives 1, else 0, zero-extended
  - 8 SRL, 9 SLL, 10 SRA
  - 11 MUL (see Configuration)
  - 4, 12–15 reserved
- Shift amount is Y[SHW-1:0]; upper Y bits are ignored.
- Shifts move one bit per cycle from the latched X. SRA replicates X[WIDTH-1].
- MUL is unsigned shift-add over WIDTH iterations. Z is the low WIDTH bits of the product; overflow=1 if the high WIDTH bits are nonzero.
- Reserved ops: Z=0, overflow=0, zero=0. equal is still computed.
- overflow is 0 for every op except ADD, SUB and MUL.
- FSM states:
  - IDLE: busy=0. On start, latch operands and go to RUN.
  - RUN: busy=1. Iterate a down-counter. When the counter reaches 0, write Z and the flags, pulse done, and return to IDLE.
- Z and all flags update only in the done cycle and hold until the next completion.

## Timing
- Accept: start=1 with busy=0 at edge k.
- Latency L is the number of edges from accept to the edge that raises done:
  - L=1 for ops 0–7 and reserved ops
  - L=max(1, shamt) for shifts
  - L=WIDTH for MUL
- busy is high from edge k+1 until edge k+L. It is low in the done cycle.
- Back-to-back: start is accepted in the same cycle done is high, because busy=0. Throughput for single-cycle ops is one per 2 cycles.
- start while busy=1 is ignored: no queueing, no error.
- X, Y and op_code may change freely after accept.
- Reset values: busy=0, done=0, Z=0, overflow=0, equal=0, zero=0; FSM in IDLE.
- Reset asserted mid-operation aborts the operation: no done, and outputs return to reset values immediately (asynchronous).

## Configuration
- ALU_MC_MUL_EN defined:
  - op_code 11 is MUL as specified.
  - Adds a 2·WIDTH-bit accumulator.
- ALU_MC_MUL_EN undefined:
  - op_code 11 is reserved: Z=0, zero=0, overflow=0, L=1.
  - No multiplier hardware is synthesised.

## Test plan
- Reset: hold rst=1 with clk running; release. Required: busy=0, done=0, Z=0, all flags 0. Assert rst during a 20-cycle SRL: busy drops at once and done never pulses.
- ADD overflow (WIDTH=32), X=0x7FFFFFFF, Y=1, op 5. Required: done at k+1, Z=0x80000000, overflow=1, zero=0, equal=0. Then SUB with X=Y=0x1234, op 6. Required: Z=0, zero=1, equal=1, overflow=0.
- SRA, X=0x80000000, Y=0x00000104 (shamt=4), op 10. Required: busy for edges k+1..k+3, done at k+4, Z=0xF8000000. Repeat with Y=0: done at k+1, Z=0x80000000.
- Ignored start: during a shamt=31 SLL of X=1, pulse start with op 0 at k+5. Required: single done at k+31, Z=0x80000000, op 0 never executed.
- MUL (ALU_MC_MUL_EN defined), X=0x00010000, Y=0x00010000. Required: done at k+32, Z=0, overflow=1, zero=1. Same stimulus with the macro undefined: done at k+1, Z=0, zero=0, overflow=0.
- Reserved op 4 followed immediately by op 7 (X=0xFFFFFFFF, Y=1) started in the done cycle. Required: first result Z=0, zero=0; second result accepted back-to-back, done 2 cycles after the first done, Z=1.

Source files
------------

// File: rtl/alu_mc_if.sv
// alu_mc_if: operand/result bundle between the register-file read stage and alu_mc.
// master drives the request side, slave is the ALU.
interface alu_mc_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [3:0]       op_code;
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Z;
  logic             overflow;
  logic             equal;
  logic             zero;

  modport master (
    output start, op_code, X, Y,
    input  busy, done, Z, overflow, equal, zero
  );

  modport slave (
    input  start, op_code, X, Y,
    output busy, done, Z, overflow, equal, zero
  );
endinterface

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with a start/busy/done handshake.
// Logic, add/sub and SLT finish in one cycle. Shifts move one bit per cycle.
// Optional unsigned shift-add multiply is enabled by defining ALU_MC_MUL_EN.
// When the macro is undefined, op_code 11 behaves as a reserved op.
module alu_mc #(
  parameter int unsigned WIDTH = 32
) (
  input logic      clk,
  input logic      rst,
  alu_mc_if.slave  bus
);
  localparam int unsigned SHW = $clog2(WIDTH);

  typedef enum logic {StIdle, StRun} state_e;

  state_e           state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, sh_q, sh_step;
  logic             eq_q, shz_q;
  logic [SHW-1:0]   lat_m1, shamt_in;
  logic             accept, finish;
  logic [WIDTH-1:0] res, sum, diff;
  logic             ovf, rsv;
  logic [WIDTH-1:0] z_q;
  logic             done_q, ovf_q, equal_q, zero_q;

`ifdef ALU_MC_MUL_EN
  // Low half starts as the multiplier; the product shifts in from the top.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH:0]     acc_hi;

  // One shift-add step of the unsigned multiply.
  always_comb begin
    acc_hi = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
    if (acc_q[0]) begin
      acc_hi = acc_hi + {1'b0, a_q};
    end
    acc_d = {acc_hi, acc_q[WIDTH-1:1]};
  end
`endif

  // Number of extra RUN cycles for the op being offered at the input.
  always_comb begin
    shamt_in = bus.Y[SHW-1:0];
    lat_m1   = '0;
    case (bus.op_code)
      4'd8, 4'd9, 4'd10: lat_m1 = (shamt_in == '0) ? '0 : shamt_in - SHW'(1);
`ifdef ALU_MC_MUL_EN
      4'd11:             lat_m1 = SHW'(WIDTH - 1);
`endif
      default:           lat_m1 = '0;
    endcase
  end

  // Single-bit shift of the working register for the latched shift op.
  always_comb begin
    sh_step = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]};
    if (op_q == 4'd8) begin
      sh_step = {1'b0, sh_q[WIDTH-1:1]};
    end else if (op_q == 4'd9) begin
      sh_step = {sh_q[WIDTH-2:0], 1'b0};
    end
  end

  // Final result and overflow, valid in the completing cycle.
  always_comb begin
    res  = '0;
    ovf  = 1'b0;
    rsv  = 1'b0;
    sum  = a_q + b_q;
    diff = a_q - b_q;
    case (op_q)
      4'd0: res = a_q & b_q;
      4'd1: res = a_q | b_q;
      4'd2: res = a_q ^ b_q;
      4'd3: res = ~(a_q | b_q);
      4'd5: begin
        res = sum;
        ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      4'd6: begin
        res = diff;
        ovf = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
      end
      4'd7: res = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      // A zero shift amount completes without moving any bits.
      4'd8, 4'd9, 4'd10: res = shz_q ? sh_q : sh_step;
`ifdef ALU_MC_MUL_EN
      4'd11: begin
        res = acc_d[WIDTH-1:0];
        ovf = |acc_d[2*WIDTH-1:WIDTH];
      end
`endif
      default: rsv = 1'b1;
    endcase
  end

  // Handshake FSM: accept in IDLE, count down in RUN, finish at zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    finish  = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          accept  = 1'b1;
          cnt_d   = lat_m1;
          state_d = StRun;
        end
      end
      StRun: begin
        if (cnt_q == '0) begin
          finish  = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - SHW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, operand latches and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sh_q    <= '0;
      eq_q    <= 1'b0;
      shz_q   <= 1'b0;
      z_q     <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      equal_q <= 1'b0;
      zero_q  <= 1'b0;
`ifdef ALU_MC_MUL_EN
      acc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= finish;
      if (accept) begin
        op_q  <= bus.op_code;
        a_q   <= bus.X;
        b_q   <= bus.Y;
        sh_q  <= bus.X;
        eq_q  <= (bus.X == bus.Y);
        shz_q <= (shamt_in == '0);
`ifdef ALU_MC_MUL_EN
        acc_q <= {{WIDTH{1'b0}}, bus.Y};
`endif
      end else if (state_q == StRun) begin
        sh_q  <= sh_step;
`ifdef ALU_MC_MUL_EN
        acc_q <= acc_d;
`endif
      end
      if (finish) begin
        z_q     <= res;
        ovf_q   <= ovf;
        equal_q <= eq_q;
        zero_q  <= (res == '0) && !rsv;
      end
    end
  end

  assign bus.busy     = (state_q == StRun);
  assign bus.done     = done_q;
  assign bus.Z        = z_q;
  assign bus.overflow = ovf_q;
  assign bus.equal    = equal_q;
  assign bus.zero     = zero_q;
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed vectors for alu_mc (WIDTH=32) with an arithmetic reference model
// compared on every falling edge, plus literal expectations for the key cases.
module tb_alu_mc;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  alu_mc_if #(.WIDTH(32)) bus ();

  alu_mc #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

`ifdef ALU_MC_MUL_EN
  localparam bit MulEn = 1'b1;
`else
  localparam bit MulEn = 1'b0;
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: what an op must produce, from plain arithmetic.
  function automatic void compute(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] z, output logic ov, output logic zr,
                                  output int lat);
    longint s;
    logic [63:0] p;
    int sh;
    bit reserved;
    sh = int'(y[4:0]);
    reserved = 1'b0;
    z = '0;
    ov = 1'b0;
    lat = 1;
    case (op)
      4'd0: z = x & y;
      4'd1: z = x | y;
      4'd2: z = x ^ y;
      4'd3: z = ~(x | y);
      4'd5: begin
        s = longint'($signed(x)) + longint'($signed(y));
        z = x + y;
        ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd6: begin
        s = longint'($signed(x)) - longint'($signed(y));
        z = x - y;
        ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd7: z = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd8: begin z = x >> sh; lat = (sh == 0) ? 1 : sh; end
      4'd9: begin z = x << sh; lat = (sh == 0) ? 1 : sh; end
      4'd10: begin z = $signed(x) >>> sh; lat = (sh == 0) ? 1 : sh; end
      4'd11: begin
        if (MulEn) begin
          p = {32'd0, x} * {32'd0, y};
          z = p[31:0];
          ov = (p[63:32] != 32'd0);
          lat = 32;
        end else begin
          reserved = 1'b1;
        end
      end
      default: reserved = 1'b1;
    endcase
    zr = !reserved && (z == 32'd0);
  endfunction

  // Model state: busy/done timing and the held result registers.
  logic        m_busy, m_done, m_ov, m_eq, m_zero;
  logic [31:0] m_z;
  int          m_rem;
  logic [31:0] p_z, c_z;
  logic        p_ov, p_zero, p_eq, c_ov, c_zr;
  int          c_lat;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_z <= '0; m_ov <= 1'b0; m_eq <= 1'b0; m_zero <= 1'b0;
      m_rem  <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (m_rem == 1) begin
          m_busy <= 1'b0; m_done <= 1'b1;
          m_z <= p_z; m_ov <= p_ov; m_zero <= p_zero; m_eq <= p_eq;
        end else begin
          m_rem <= m_rem - 1;
        end
      end else if (bus.start) begin
        compute(bus.op_code, bus.X, bus.Y, c_z, c_ov, c_zr, c_lat);
        p_z <= c_z; p_ov <= c_ov; p_zero <= c_zr; p_eq <= (bus.X == bus.Y);
        m_rem <= c_lat;
        m_busy <= 1'b1;
      end
    end
  end

  // Every cycle: outputs must match the model.
  always @(negedge clk) begin
    check("busy", 64'(bus.busy), 64'(m_busy));
    check("done", 64'(bus.done), 64'(m_done));
    check("Z", 64'(bus.Z), 64'(m_z));
    check("overflow", 64'(bus.overflow), 64'(m_ov));
    check("equal", 64'(bus.equal), 64'(m_eq));
    check("zero", 64'(bus.zero), 64'(m_zero));
  end

  // Count edges until done rises; a missing done is a failed comparison.
  task automatic wait_done(output int n);
    n = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        n = i;
        break;
      end
    end
    if (n == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout: got no done expected done within 100 edges");
    end
  endtask

  // Start one op, then scramble the inputs to prove they were latched.
  task automatic run_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                        output int lat);
    @(negedge clk); #1;
    bus.start = 1'b1; bus.op_code = op; bus.X = x; bus.Y = y;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.X = ~x; bus.Y = ~y; bus.op_code = op ^ 4'h3;
    wait_done(lat);
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] x, y, z;
    int          lat;
  } vec_t;

  vec_t tbl[6] = '{
    '{4'd0, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1},
    '{4'd1, 32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0, 1},
    '{4'd2, 32'h0000F0F0, 32'h0000FF00, 32'h00000FF0, 1},
    '{4'd3, 32'hF0F0F0F0, 32'h0F0F0000, 32'h00000F0F, 1},
    '{4'd8, 32'h80000000, 32'h00000003, 32'h10000000, 3},
    '{4'd9, 32'h00000003, 32'h00000021, 32'h00000006, 1}
  };

  initial begin
    int lat, n, dones;
    bus.start = 1'b0; bus.op_code = '0; bus.X = '0; bus.Y = '0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_Z", 64'(bus.Z), 64'd0);
    check("rst_flags", 64'({bus.overflow, bus.equal, bus.zero}), 64'd0);
    #1 rst = 1'b0;

    // Signed add overflow, then equal-operand subtract.
    run_op(4'd5, 32'h7FFFFFFF, 32'h00000001, lat);
    check("add_lat", 64'(lat), 64'd1);
    check("add_Z", 64'(bus.Z), 64'h80000000);
    check("add_flags", 64'({bus.overflow, bus.zero, bus.equal}), 64'b100);
    run_op(4'd6, 32'h00001234, 32'h00001234, lat);
    check("sub_Z", 64'(bus.Z), 64'd0);
    check("sub_flags", 64'({bus.overflow, bus.zero, bus.equal}), 64'b011);

    // Arithmetic right shift by 4 (upper Y bits ignored), then by 0.
    run_op(4'd10, 32'h80000000, 32'h00000104, lat);
    check("sra_lat", 64'(lat), 64'd4);
    check("sra_Z", 64'(bus.Z), 64'hF8000000);
    run_op(4'd10, 32'h80000000, 32'h00000000, lat);
    check("sra0_lat", 64'(lat), 64'd1);
    check("sra0_Z", 64'(bus.Z), 64'h80000000);

    for (int i = 0; i < 6; i++) begin
      run_op(tbl[i].op, tbl[i].x, tbl[i].y, lat);
      check($sformatf("tbl%0d_lat", i), 64'(lat), 64'(tbl[i].lat));
      check($sformatf("tbl%0d_Z", i), 64'(bus.Z), 64'(tbl[i].z));
    end

    // Long SLL with a stray start at k+5 that must be ignored.
    @(negedge clk); #1;
    bus.start = 1'b1; bus.op_code = 4'd9; bus.X = 32'd1; bus.Y = 32'd31;
    @(posedge clk); #1;
    bus.start = 1'b0;
    dones = 0; lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (i == 4) begin
        bus.start = 1'b1; bus.op_code = 4'd0; bus.X = 32'hFFFF; bus.Y = 32'hFF;
      end
      if (i == 5) bus.start = 1'b0;
      if (bus.done) begin
        dones++;
        lat = i;
      end
    end
    check("sll_lat", 64'(lat), 64'd31);
    check("sll_dones", 64'(dones), 64'd1);
    check("sll_Z", 64'(bus.Z), 64'h80000000);

    // Multiply, or reserved op 11 when multiply is compiled out.
    run_op(4'd11, 32'h00010000, 32'h00010000, lat);
    check("mul_Z", 64'(bus.Z), 64'd0);
    if (MulEn) begin
      check("mul_lat", 64'(lat), 64'd32);
      check("mul_flags", 64'({bus.overflow, bus.zero}), 64'b11);
    end else begin
      check("mul_lat", 64'(lat), 64'd1);
      check("mul_flags", 64'({bus.overflow, bus.zero}), 64'b00);
    end

    // Reserved op, then SLT started in its done cycle.
    run_op(4'd4, 32'h00000005, 32'h00000005, lat);
    check("rsv_Z", 64'(bus.Z), 64'd0);
    check("rsv_flags", 64'({bus.overflow, bus.zero, bus.equal}), 64'b001);
    bus.start = 1'b1; bus.op_code = 4'd7; bus.X = 32'hFFFFFFFF; bus.Y = 32'd1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(n);
    check("b2b_gap", 64'(n + 1), 64'd2);
    check("slt_Z", 64'(bus.Z), 64'd1);

    // Reset in the middle of a 20-cycle SRL.
    @(negedge clk); #1;
    bus.start = 1'b1; bus.op_code = 4'd8; bus.X = 32'hFFFF0000; bus.Y = 32'd20;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_Z", 64'(bus.Z), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (bus.done) dones++;
    end
    check("abort_no_done", 64'(dones), 64'd0);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1);
  end
endmodule
